// File: rtl/rail_pkg.sv
// Shared types and constants for the railway crossbar switch controller.
package rail_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic ROUTE_STRAIGHT = 1'b0;
  localparam logic ROUTE_CROSS    = 1'b1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/railway_switch_controller_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the port not served last.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win_c
);

  always_comb begin
    o_win_c = 2'b00;
    if (i_req == 2'b11) begin
      o_win_c = i_last ? 2'b01 : 2'b10;
    end else begin
      o_win_c = i_req;
    end
  end

endmodule

// File: rtl/railway_switch_controller.sv
// Arbitrates exclusive use of the two-track crossbar, moves sel only with no grant held,
// waits out a settle time after each route change and forces release after a hold limit.
module railway_switch_controller
  import rail_pkg::*;
#(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] route,
  input  logic [1:0] done,
  output logic       sel,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned HC_W  = $clog2(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic             r_sel, w_sel_nxt;
  logic [1:0]       r_grant, w_grant_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_to, w_to_nxt;
  logic             r_last, w_last_nxt;
  logic             r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [HC_W-1:0]  r_hc, w_hc_nxt;

  logic [1:0]       w_win;
  logic             w_win_idx;
  logic             w_own_req;
  logic             w_own_done;

  rr_arb2 u_arb (
    .i_req   (req),
    .i_last  (r_last),
    .o_win_c (w_win)
  );

  assign w_win_idx  = w_win[1];
  assign w_own_req  = req[r_owner];
  assign w_own_done = done[r_owner];

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= ROUTE_STRAIGHT;
      r_grant <= 2'b00;
      r_busy  <= 1'b0;
      r_to    <= 1'b0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_hc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_to    <= w_to_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hc    <= w_hc_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_to_nxt    = 1'b0;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_hc_nxt    = r_hc;

    unique case (r_state)
      IDLE: begin
        w_grant_nxt = 2'b00;
        if (|req) begin
          w_owner_nxt = w_win_idx;
          if (route[w_win_idx] == r_sel) begin
            w_state_nxt = LOCKED;
            w_grant_nxt = onehot2(w_win_idx);
            w_hc_nxt    = '0;
          end else begin
            w_state_nxt = MOVE;
            w_sel_nxt   = route[w_win_idx];
            w_cnt_nxt   = CNT_W'(SETTLE - 1);
          end
        end
      end

      MOVE: begin
        // Owner giving up mid-settle wins over the settle expiring.
        if (!w_own_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = onehot2(r_owner);
          w_hc_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      LOCKED: begin
        if (w_own_done || !w_own_req) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
          w_last_nxt  = r_owner;
        end else if (r_hc == HC_W'(MAX_HOLD - 1)) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
          w_to_nxt    = 1'b1;
          w_last_nxt  = r_owner;
        end else begin
          w_hc_nxt = r_hc + HC_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign sel         = r_sel;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_to;

endmodule

// File: tb/tb_railway_switch_controller.sv
// Scoreboard bench: stimulus queues each expected output change with its edge number,
// a negedge monitor pops and compares whenever {sel,grant,busy,timeout_err} changes.
module tb_railway_switch_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] route;
  logic [1:0] done;
  logic       sel;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  railway_switch_controller #(
    .SETTLE   (4),
    .MAX_HOLD (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .route       (route),
    .done        (done),
    .sel         (sel),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int         cyc;
    logic [4:0] obs;
  } exp_t;

  exp_t       sb[$];
  int         cyc        = 0;
  int         errors     = 0;
  int         checks     = 0;
  logic [4:0] prev_obs   = 5'b0;
  logic       prev_sel   = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic s, input logic [1:0] g,
                      input logic b, input logic t);
    exp_t e;
    e.cyc = c;
    e.obs = {s, g, b, t};
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: sel/grant/busy/to got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every output change.
  always @(negedge clk) begin
    logic [4:0] obs;
    exp_t       e;
    obs = {sel, grant, busy, timeout_err};
    checks++;
    if (grant === 2'b11 ||
        (prev_grant !== 2'b00 && grant !== 2'b00 && sel !== prev_sel)) begin
      errors++;
      $display("FAIL invariant cyc=%0d: grant=%b sel=%b prev_grant=%b prev_sel=%b",
               cyc, grant, sel, prev_grant, prev_sel);
    end
    if (obs !== prev_obs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d: got %b, nothing expected", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.obs !== obs) begin
          errors++;
          $display("FAIL event: got cyc=%0d obs=%b expected cyc=%0d obs=%b",
                   cyc, obs, e.cyc, e.obs);
        end
      end
      prev_obs = obs;
    end
    prev_sel   = sel;
    prev_grant = grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req   = 2'b00;
    route = 2'b00;
    done  = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {sel, grant, busy, timeout_err}, 5'b0);

    // Both request from reset: port 0 first, then port 1, then port 0 again.
    req = 2'b11; route = 2'b00;
    push(cyc + 1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    done = 2'b01;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    done = 2'b00;
    push(cyc + 1, 1'b0, 2'b10, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    done = 2'b10;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    done = 2'b00;
    push(cyc + 1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    done = 2'b01;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    done = 2'b00; req = 2'b00;
    repeat (2) @(negedge clk);

    // Single port 0, straight route already set: one-cycle grant latency.
    req = 2'b01; route = 2'b00;
    push(cyc + 1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    done = 2'b01;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    done = 2'b00; req = 2'b00;
    repeat (2) @(negedge clk);

    // Port 0 served last, so port 1 wins the tie; owner dropping req releases.
    req = 2'b11; route = 2'b00;
    push(cyc + 1, 1'b0, 2'b10, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    req = 2'b01;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    push(cyc + 1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    req = 2'b00;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Port 1 crossed: sel flips next edge, grant after 1+SETTLE edges.
    req = 2'b10; route = 2'b10;
    push(cyc + 1, 1'b1, 2'b00, 1'b1, 1'b0);
    push(cyc + 5, 1'b1, 2'b10, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    done = 2'b10;
    push(cyc + 1, 1'b1, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    done = 2'b00; req = 2'b00;
    repeat (2) @(negedge clk);

    // Hold without release: forced release after 64 granted cycles.
    // Route toggle and non-owner done mid-hold must not disturb anything.
    req = 2'b01; route = 2'b01;
    push(cyc + 1,  1'b1, 2'b01, 1'b1, 1'b0);
    push(cyc + 65, 1'b1, 2'b00, 1'b0, 1'b1);
    push(cyc + 66, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    route = 2'b00; done = 2'b10;
    @(negedge clk);
    done = 2'b00;
    repeat (61) @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Port 0 straight from sel=1: move back to 0 and grant.
    req = 2'b01; route = 2'b00;
    push(cyc + 1, 1'b0, 2'b00, 1'b1, 1'b0);
    push(cyc + 5, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    req = 2'b00;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Port 1 drops req during the settle: abort, sel keeps its new value.
    req = 2'b10; route = 2'b10;
    push(cyc + 1, 1'b1, 2'b00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    req = 2'b00;
    push(cyc + 1, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset asserted off-edge while port 0 holds the grant.
    req = 2'b01; route = 2'b01;
    push(cyc + 1, 1'b1, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async", {sel, grant, busy, timeout_err}, 5'b0);
    @(negedge clk);
    rst = 1'b0; req = 2'b11; route = 2'b00;
    push(cyc + 1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    req = 2'b00;
    push(cyc + 1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
